// File: rtl/instr_fetch_seq_if.sv
// Bundles the sequencer's signals toward the instruction ROM, the control decoder,
// the jump LUT and the program controller.
//   master : the sequencer (drives prog_addr, instr, opcode, instr_valid, done)
//   slave  : the surrounding system (drives start, stall, rom_data, decoder answers)
// Optional macro FETCH_PERF_EN adds the instr_cnt / taken_cnt performance counters.
interface instr_fetch_seq_if #(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned OP_W    = 4
);
    logic               start;
    logic               stall;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic [OP_W-1:0]    opcode;
    logic               instr_valid;
    logic               uncd_jmp;
    logic               j_type;
    logic               br_flag;
    logic [PC_W-1:0]    jmp_target;
    logic               done;
`ifdef FETCH_PERF_EN
    logic [15:0]        instr_cnt;
    logic [15:0]        taken_cnt;
`endif

    modport master (
        input  start, stall, rom_data, uncd_jmp, j_type, br_flag, jmp_target,
`ifdef FETCH_PERF_EN
        output instr_cnt, taken_cnt,
`endif
        output prog_addr, instr, opcode, instr_valid, done
    );

    modport slave (
        output start, stall, rom_data, uncd_jmp, j_type, br_flag, jmp_target,
`ifdef FETCH_PERF_EN
        input  instr_cnt, taken_cnt,
`endif
        input  prog_addr, instr, opcode, instr_valid, done
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch / sequencer. Owns the PC, reads the instruction ROM, presents
// each instruction to the control decoder and picks the next PC from the decoder's
// jump answer and the ALU branch flag. Two cycles per instruction (FETCH, EXEC).
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high; discards any in-flight instruction
//   bus   : instr_fetch_seq_if.master (start/stall in, ROM address/data,
//           instruction + opcode + instr_valid out, decoder answers in, done out)
// Optional macro FETCH_PERF_EN: adds saturating instr_cnt / taken_cnt counters.
module instr_fetch_seq #(
    parameter int unsigned      PC_W    = 10,
    parameter int unsigned      INSTR_W = 9,
    parameter int unsigned      OP_W    = 4,
    parameter logic [OP_W-1:0]  HALT_OP = {OP_W{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_seq_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [OP_W-1:0]    op_c;
    logic               taken_c;

    assign op_c    = instr_q[INSTR_W-1 -: OP_W];
    // A jump needs the decoder's jump class; UncdJmp alone is an ordinary instruction.
    assign taken_c = bus.j_type & (bus.uncd_jmp | bus.br_flag);

`ifdef FETCH_PERF_EN
    logic [15:0] icnt_q, icnt_d;
    logic [15:0] tcnt_q, tcnt_d;
`endif

    // Next-state, next-PC and next-output logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        done_d  = done_q;
`ifdef FETCH_PERF_EN
        icnt_d  = icnt_q;
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                valid_d = 1'b0;
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    done_d  = 1'b0;
`ifdef FETCH_PERF_EN
                    icnt_d  = 16'd0;
                    tcnt_d  = 16'd0;
`endif
                end
            end
            S_FETCH: begin
                // ROM data belongs to pc_q, driven since the edge that entered FETCH.
                if (!bus.stall) begin
                    instr_d = bus.rom_data;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!bus.stall) begin
                    valid_d = 1'b0;
`ifdef FETCH_PERF_EN
                    icnt_d  = (icnt_q == 16'hFFFF) ? icnt_q : icnt_q + 16'd1;
`endif
                    if (op_c == HALT_OP) begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        if (taken_c) begin
                            pc_d = bus.jmp_target;
`ifdef FETCH_PERF_EN
                            tcnt_d = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
`endif
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef FETCH_PERF_EN
            icnt_q  <= 16'd0;
            tcnt_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef FETCH_PERF_EN
            icnt_q  <= icnt_d;
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    // ROM address is the PC register itself, so both move on the same edge.
    assign bus.prog_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = op_c;
    assign bus.instr_valid = valid_q;
    assign bus.done        = done_q;
`ifdef FETCH_PERF_EN
    assign bus.instr_cnt   = icnt_q;
    assign bus.taken_cnt   = tcnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: ROM and decoder/jump-LUT answers are per-address tables
// looked up from prog_addr; a program-walk model gives the expected address trace.
module tb_instr_fetch_seq;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [8:0] rom [1024];
    logic       jt  [1024];
    logic       uj  [1024];
    logic       bf  [1024];
    logic [9:0] tgt [1024];

    instr_fetch_seq_if #(.PC_W(10), .INSTR_W(9), .OP_W(4)) bus ();

    instr_fetch_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rom_data   = rom[bus.prog_addr];
    assign bus.j_type     = jt[bus.prog_addr];
    assign bus.uncd_jmp   = uj[bus.prog_addr];
    assign bus.br_flag    = bf[bus.prog_addr];
    assign bus.jmp_target = tgt[bus.prog_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_addr"},  32'(bus.prog_addr),   32'd0);
        check({tag, "_instr"}, 32'(bus.instr),       32'd0);
        check({tag, "_done"},  32'(bus.done),        32'd0);
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 1024; a++) begin
            rom[a] = 9'h000; jt[a] = 1'b0; uj[a] = 1'b0; bf[a] = 1'b0; tgt[a] = 10'd0;
        end
    endtask

    task automatic random_prog();
        for (int a = 0; a < 1024; a++) begin
            logic [3:0] op;
            op     = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            rom[a] = {op, 5'($urandom)};
            jt[a]  = ($urandom_range(0, 2) == 0);
            uj[a]  = 1'($urandom);
            bf[a]  = 1'($urandom);
            tgt[a] = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1018, 1023))
                                                 : 10'($urandom_range(0, 63));
        end
    endtask

    function automatic int stall_len(input int mode);
        if (mode == 2) return 3;
        if (mode == 1 && $urandom_range(0, 3) == 0) return $urandom_range(1, 3);
        return 0;
    endfunction

    // Walks the program from PC 0 at instruction granularity, then checks the DUT
    // cycle by cycle. A program that has not halted after max_n instructions is
    // reset while its last instruction is in EXEC.
    task automatic run_prog(input string name, input int max_n, input int mode);
        logic [9:0]  pc;
        int unsigned q[$];
        int          n_taken;
        bit          halted;
        int          k;
        pc = 10'd0; n_taken = 0; halted = 1'b0;
        for (int n = 0; n < max_n; n++) begin
            q.push_back(32'(pc));
            if (rom[pc][8:5] == 4'hF) begin
                halted = 1'b1;
                break;
            end
            if (jt[pc] && (uj[pc] || bf[pc])) begin
                pc = tgt[pc];
                n_taken++;
            end else begin
                pc = pc + 10'd1;
            end
        end

        bus.start = 1'b1;
        bus.stall = 1'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        bus.stall = 1'b0;
`ifdef FETCH_PERF_EN
        check({name, "_icnt_clr"}, 32'(bus.instr_cnt), 32'd0);
        check({name, "_tcnt_clr"}, 32'(bus.taken_cnt), 32'd0);
`endif
        for (int i = 0; i < q.size(); i++) begin
            // FETCH (including any stalled cycles)
            k = (mode == 2) ? 0 : stall_len(mode);
            for (int s = 0; s <= k; s++) begin
                check($sformatf("%s_f_valid[%0d]", name, i), 32'(bus.instr_valid), 32'd0);
                check($sformatf("%s_f_addr[%0d]", name, i),  32'(bus.prog_addr),   q[i]);
                check($sformatf("%s_f_done[%0d]", name, i),  32'(bus.done),        32'd0);
                bus.stall = (s < k);
                @(negedge clk);
            end
            // EXEC (including any stalled cycles)
            k = stall_len(mode);
            for (int s = 0; s <= k; s++) begin
                check($sformatf("%s_e_valid[%0d]", name, i), 32'(bus.instr_valid), 32'd1);
                check($sformatf("%s_e_addr[%0d]", name, i),  32'(bus.prog_addr),   q[i]);
                check($sformatf("%s_e_instr[%0d]", name, i), 32'(bus.instr),       32'(rom[q[i]]));
                check($sformatf("%s_e_op[%0d]", name, i),    32'(bus.opcode),      32'(rom[q[i]][8:5]));
                if (!halted && i == q.size() - 1) begin
                    bus.stall = 1'($urandom);
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    bus.stall = 1'b0;
                    check_cleared({name, "_rst"});
                    return;
                end
                bus.stall = (s < k);
                @(negedge clk);
            end
        end
        // HALT: done held, stall/no-start ignored
        for (int h = 0; h < 2; h++) begin
            check($sformatf("%s_h_done[%0d]", name, h),  32'(bus.done),        32'd1);
            check($sformatf("%s_h_valid[%0d]", name, h), 32'(bus.instr_valid), 32'd0);
            check($sformatf("%s_h_addr[%0d]", name, h),  32'(bus.prog_addr),   q[q.size()-1]);
`ifdef FETCH_PERF_EN
            check($sformatf("%s_icnt[%0d]", name, h), 32'(bus.instr_cnt), 32'(q.size()));
            check($sformatf("%s_tcnt[%0d]", name, h), 32'(bus.taken_cnt), 32'(n_taken));
`endif
            bus.stall = 1'($urandom);
            @(negedge clk);
        end
        bus.stall = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; bus.start = 1'b0; bus.stall = 1'b0;
        clear_prog();
        repeat (2) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;

        // IDLE holds without start, stall ignored
        bus.stall = 1'b1;
        repeat (2) @(negedge clk);
        bus.stall = 1'b0;
        check_cleared("idle_hold");

        // add, xor, HALT
        rom[0] = {4'h0, 5'h03}; rom[1] = {4'h5, 5'h11}; rom[2] = {4'hF, 5'h00};
        run_prog("seq", 10, 0);

        // uncond jump at 3 to 10 with br_flag=0; uncd_jmp without j_type at 1
        clear_prog();
        uj[1] = 1'b1; tgt[1] = 10'd20;
        jt[3] = 1'b1; uj[3] = 1'b1; bf[3] = 1'b0; tgt[3] = 10'd10;
        rom[10] = {4'hF, 5'h1F};
        run_prog("ujmp", 10, 0);

        // cond jump not taken at 4, taken at 5 back to 0 (loops until reset)
        clear_prog();
        jt[4] = 1'b1; bf[4] = 1'b0; tgt[4] = 10'd9;
        jt[5] = 1'b1; bf[5] = 1'b1; tgt[5] = 10'd0;
        rom[2] = {4'h7, 5'h05};
        run_prog("cjmp", 14, 0);

        // 3-cycle stalls in every EXEC
        clear_prog();
        rom[1] = {4'h3, 5'h0A}; jt[2] = 1'b1; uj[2] = 1'b1; tgt[2] = 10'd6;
        rom[7] = {4'hF, 5'h00};
        run_prog("stall", 10, 2);

        // PC wrap from 1023 to 0, reset while in EXEC
        clear_prog();
        jt[0] = 1'b1; uj[0] = 1'b1; tgt[0] = 10'd1022;
        rom[1022] = {4'h9, 5'h02};
        run_prog("wrap", 6, 0);

        // jump to self
        clear_prog();
        jt[1] = 1'b1; uj[1] = 1'b1; tgt[1] = 10'd1;
        run_prog("self", 6, 1);

        // randomized programs with random stalls
        for (int r = 0; r < 12; r++) begin
            random_prog();
            run_prog($sformatf("rnd%0d", r), 40, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
